// File: rtl/nor_chain_seq.sv
// nor_chain_seq
// Bit-serial evaluation of a cascaded NOR chain. A single 2-input NOR stage
// is reused once per enabled clock; every intermediate stage is kept visible
// on stage_out and the last stage is mirrored on result.
module nor_chain_seq #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] din,
   input  logic         stall,
   output logic         busy,
   output logic         done,
   output logic [N-2:0] stage_out,
   output logic         result
);

   localparam int             IW       = $clog2(N);
   localparam logic [IW-1:0]  LAST_IDX = IW'(N - 2);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EVAL = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t        state_r;
   state_t        state_nx_s;
   logic [N-1:0]  op_r;
   logic [N-1:0]  op_nx_s;
   logic          acc_r;
   logic          acc_nx_s;
   logic [IW-1:0] idx_r;
   logic [IW-1:0] idx_nx_s;
   logic [N-2:0]  stage_r;
   logic [N-2:0]  stage_nx_s;
   logic          busy_r;
   logic          busy_nx_s;
   logic          done_r;
   logic          done_nx_s;
   logic          result_r;
   logic          result_nx_s;

   logic          opa_s;
   logic          opb_s;
   logic          nor_s;

   // Shared NOR stage: first step combines op[0] with op[1]; later steps
   // fold the accumulated stage with the next operand bit.
   always_comb begin
      opa_s = (idx_r == {IW{1'b0}}) ? op_r[0] : acc_r;
      opb_s = 1'b0;
      for (int k = 0; k < N - 1; k++) begin
         opb_s = (idx_r == IW'(k)) ? op_r[k+1] : opb_s;
      end
      nor_s = ~(opa_s | opb_s);
   end

   // Next-state and next-output logic for the IDLE/EVAL/DONE sequencer.
   always_comb begin
      state_nx_s  = state_r;
      op_nx_s     = op_r;
      acc_nx_s    = acc_r;
      idx_nx_s    = idx_r;
      stage_nx_s  = stage_r;
      busy_nx_s   = busy_r;
      done_nx_s   = done_r;

      case (state_r)
         IDLE: begin
            if (start) begin
               op_nx_s    = din;
               acc_nx_s   = 1'b0;
               idx_nx_s   = {IW{1'b0}};
               stage_nx_s = {(N-1){1'b0}};
               busy_nx_s  = 1'b1;
               done_nx_s  = 1'b0;
               state_nx_s = EVAL;
            end else begin
               state_nx_s = IDLE;
            end
         end
         EVAL: begin
            if (!stall) begin
               for (int k = 0; k < N - 1; k++) begin
                  stage_nx_s[k] = (idx_r == IW'(k)) ? nor_s : stage_r[k];
               end
               acc_nx_s = nor_s;
               if (idx_r == LAST_IDX) begin
                  busy_nx_s  = 1'b0;
                  done_nx_s  = 1'b1;
                  state_nx_s = DONE;
               end else begin
                  idx_nx_s   = idx_r + IW'(1);
               end
            end else begin
               state_nx_s = EVAL;
            end
         end
         DONE: begin
            done_nx_s  = 1'b0;
            state_nx_s = IDLE;
         end
         default: begin
            busy_nx_s  = 1'b0;
            done_nx_s  = 1'b0;
            state_nx_s = IDLE;
         end
      endcase

      result_nx_s = stage_nx_s[N-2];
   end

   // State and datapath registers; reset clears everything back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         op_r     <= {N{1'b0}};
         acc_r    <= 1'b0;
         idx_r    <= {IW{1'b0}};
         stage_r  <= {(N-1){1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         op_r     <= op_nx_s;
         acc_r    <= acc_nx_s;
         idx_r    <= idx_nx_s;
         stage_r  <= stage_nx_s;
         busy_r   <= busy_nx_s;
         done_r   <= done_nx_s;
         result_r <= result_nx_s;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign stage_out = stage_r;
   assign result    = result_r;

endmodule

// File: tb/tb_nor_chain_seq.sv
// Scoreboard bench for nor_chain_seq: the driver issues operations (with
// random stalls and ignored start pokes) and queues the expected chain value
// and completion cycle; an independent monitor checks every done pulse.
module tb_nor_chain_seq;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] din;
   logic         stall;
   logic         busy;
   logic         done;
   logic [N-2:0] stage_out;
   logic         result;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [N-2:0] stage;
      int           due;
   } exp_t;

   exp_t sb[$];

   nor_chain_seq #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .din       (din),
      .stall     (stall),
      .busy      (busy),
      .done      (done),
      .stage_out (stage_out),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so the monitor can check completion timing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: stage0 = ~(d0|d1), stage k = ~(d[k+1] | stage k-1).
   function automatic logic [N-2:0] chain(input logic [N-1:0] d);
      logic [N-2:0] s;
      s[0] = ~(d[0] | d[1]);
      for (int k = 1; k < N - 1; k++) s[k] = ~(d[k+1] | s[k-1]);
      return s;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         check("busy_done_exclusive", 32'(busy & done), 32'd0);
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("stage_out", 32'(stage_out), 32'(e.stage));
               check("result", 32'(result), 32'(e.stage[N-2]));
               check("done_cycle", 32'(cyc), 32'(e.due));
            end
         end else if (sb.size() > 0 && cyc > sb[0].due) begin
            exp_t e;
            e = sb.pop_front();
            check("done_missing", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         start = 1'b0;
         stall = 1'b0;
      end
   endtask

   // One operation: start in an IDLE cycle, then drive a stall pattern
   // containing exactly N-1 unstalled EVAL cycles; returns in the DONE cycle.
   task automatic run_op(input logic [N-1:0] d, input logic [N-2:0] exp_v,
                         input bit rnd_stall, input int fixed_stalls, input bit poke);
      bit   pat[$];
      int   unst;
      int   nst;
      exp_t e;
      logic [N-2:0] mask;
      unst = 0;
      nst  = 0;
      while (unst < N - 1) begin
         bit b;
         if (rnd_stall) b = ($urandom_range(0, 3) == 0);
         else           b = (unst == 1 && nst < fixed_stalls);
         pat.push_back(b);
         if (b) nst++;
         else   unst++;
      end
      @(negedge clk);
      start = 1'b1;
      din   = d;
      stall = 1'b0;
      e.stage = exp_v;
      e.due   = cyc + N + nst;
      sb.push_back(e);
      unst = 0;
      foreach (pat[i]) begin
         @(negedge clk);
         mask = '0;
         for (int k = 0; k < N - 1; k++) if (k < unst) mask[k] = 1'b1;
         check("busy_in_eval", 32'(busy), 32'd1);
         check("partial_stages", 32'(stage_out), 32'(exp_v & mask));
         start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         din   = poke ? ~d : d;
         stall = pat[i];
         if (!pat[i]) unst++;
      end
      @(negedge clk);
      check("busy_in_done", 32'(busy), 32'd0);
      stall = 1'b0;
      start = poke;
      din   = ~d;
   endtask

   // Abort an operation with a one-cycle reset after stage 0 is written.
   task automatic reset_mid(input logic [N-1:0] d);
      @(negedge clk);
      start = 1'b1;
      din   = d;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("aborted_stage0", 32'(stage_out[0]), 32'(chain(d) & 1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_stage_out", 32'(stage_out), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      idle(N + 2);
   endtask

   initial begin
      logic [N-1:0] d;
      rst   = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      din   = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({busy, done, stage_out, result}), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_outputs", 32'({busy, done, stage_out, result}), 32'd0);
      end

      run_op(4'b0000, 3'b101, 1'b0, 0, 1'b0);
      idle(2);
      run_op(4'b0001, 3'b010, 1'b0, 0, 1'b0);
      run_op(4'b1000, 3'b001, 1'b0, 0, 1'b0);
      idle(1);
      run_op(4'b0000, 3'b101, 1'b0, 2, 1'b0);
      run_op(4'b0110, chain(4'b0110), 1'b0, 0, 1'b1);
      idle(1);
      check("hold_after_done", 32'(stage_out), 32'(chain(4'b0110)));
      reset_mid(4'b0000);
      run_op(4'b0100, chain(4'b0100), 1'b0, 0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         d = N'($urandom);
         run_op(d, chain(d), 1'b1, 0, 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2));
      end

      idle(6);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
